// File: rtl/cosine_sim_engine.sv
// Serial cosine-similarity engine: MAC over element pairs, bit-serial integer sqrt,
// then restoring divide to a signed Q1.FRAC_W result.
module cosine_sim_engine #(
    parameter int unsigned N_ELEM = 4,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned FRAC_W = 15
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [N_ELEM*ELEM_W-1:0]            A_vec,
    input  logic [N_ELEM*ELEM_W-1:0]            B_vec,
    output logic                                busy,
    output logic                                done,
    output logic                                zero_vec,
    output logic [2*ELEM_W+$clog2(N_ELEM):0]    dot_product,
    output logic [FRAC_W:0]                     cosine_similarity
);

    localparam int unsigned VEC_W  = N_ELEM * ELEM_W;
    localparam int unsigned NW     = 2 * ELEM_W + $clog2(N_ELEM);
    localparam int unsigned DOT_W  = NW + 1;
    localparam int unsigned RES_W  = FRAC_W + 1;
    localparam int unsigned PROD_W = 2 * ELEM_W;
    localparam int unsigned SW     = NW + FRAC_W;
    localparam int unsigned RAD_W  = 2 * SW;
    localparam int unsigned RW     = SW + 4;
    localparam int unsigned QW     = FRAC_W + 1;
    localparam int unsigned IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned CNT_W  = $clog2(SW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_SQRT,
        S_DIV,
        S_DONE
    } state_t;

    state_t                    state;
    logic [VEC_W-1:0]          a_lat;
    logic [VEC_W-1:0]          b_lat;
    logic [IDX_W-1:0]          idx;
    logic signed [DOT_W-1:0]   dot_acc;
    logic [NW-1:0]             na_acc;
    logic [NW-1:0]             nb_acc;
    logic [RAD_W-1:0]          rad;
    logic [SW-1:0]             sq_root;
    logic [SW+1:0]             sq_rem;
    logic [CNT_W-1:0]          cnt;
    logic [SW-1:0]             dv_rem;
    logic [SW-1:0]             dv_div;
    logic [QW-2:0]             quo;

    logic signed [ELEM_W-1:0]  a_el;
    logic signed [ELEM_W-1:0]  b_el;
    logic signed [PROD_W-1:0]  p_ab;
    logic signed [PROD_W-1:0]  p_aa;
    logic signed [PROD_W-1:0]  p_bb;
    logic signed [DOT_W-1:0]   dot_nxt;
    logic [NW-1:0]             na_nxt;
    logic [NW-1:0]             nb_nxt;
    logic [2*NW-1:0]           norm_prod;
    logic [RAD_W-1:0]          rad_init;
    logic [RW-1:0]             sq_shift;
    logic [RW-1:0]             sq_trial;
    logic                      sq_ge;
    logic [SW+1:0]             sq_rem_nxt;
    logic [SW-1:0]             sq_root_nxt;
    logic [DOT_W-1:0]          abs_dot;
    logic [SW:0]               dv_shift;
    logic                      dv_ge;
    logic [SW-1:0]             dv_rem_nxt;
    logic [QW-1:0]             quo_nxt;
    logic [RES_W-1:0]          cos_res;

    // Datapath step for the current element, sqrt bit and quotient bit
    always_comb begin
        a_el        = '0;
        b_el        = '0;
        a_el        = a_lat[idx*ELEM_W +: ELEM_W];
        b_el        = b_lat[idx*ELEM_W +: ELEM_W];
        p_ab        = a_el * b_el;
        p_aa        = a_el * a_el;
        p_bb        = b_el * b_el;
        dot_nxt     = dot_acc + {{(DOT_W-PROD_W){p_ab[PROD_W-1]}}, p_ab};
        na_nxt      = na_acc + NW'(p_aa);
        nb_nxt      = nb_acc + NW'(p_bb);
        norm_prod   = (2*NW)'(na_nxt) * (2*NW)'(nb_nxt);
        rad_init    = {norm_prod, (2*FRAC_W)'(0)};

        sq_shift    = {sq_rem, rad[RAD_W-1 -: 2]};
        sq_trial    = RW'({sq_root, 2'b01});
        sq_ge       = (sq_shift >= sq_trial);
        sq_rem_nxt  = (SW+2)'(sq_ge ? sq_shift - sq_trial : sq_shift);
        sq_root_nxt = {sq_root[SW-2:0], sq_ge};

        abs_dot     = dot_acc[DOT_W-1] ? DOT_W'(-dot_acc) : DOT_W'(dot_acc);
        dv_shift    = {dv_rem, 1'b0};
        dv_ge       = (dv_shift >= {1'b0, dv_div});
        dv_rem_nxt  = SW'(dv_ge ? dv_shift - {1'b0, dv_div} : dv_shift);
        quo_nxt     = {quo, dv_ge};

        // Positive full-scale (q == 2^FRAC_W) saturates; negative full-scale is exact
        if (dot_acc[DOT_W-1]) begin
            cos_res = RES_W'(-quo_nxt);
        end else if (quo_nxt[QW-1]) begin
            cos_res = {1'b0, {FRAC_W{1'b1}}};
        end else begin
            cos_res = quo_nxt;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            a_lat             <= '0;
            b_lat             <= '0;
            idx               <= '0;
            dot_acc           <= '0;
            na_acc            <= '0;
            nb_acc            <= '0;
            rad               <= '0;
            sq_root           <= '0;
            sq_rem            <= '0;
            cnt               <= '0;
            dv_rem            <= '0;
            dv_div            <= '0;
            quo               <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            zero_vec          <= 1'b0;
            dot_product       <= '0;
            cosine_similarity <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_lat   <= A_vec;
                        b_lat   <= B_vec;
                        idx     <= '0;
                        dot_acc <= '0;
                        na_acc  <= '0;
                        nb_acc  <= '0;
                        busy    <= 1'b1;
                        state   <= S_MAC;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_MAC: begin
                    dot_acc <= dot_nxt;
                    na_acc  <= na_nxt;
                    nb_acc  <= nb_nxt;
                    idx     <= idx + IDX_W'(1);
                    if (idx == IDX_W'(N_ELEM - 1)) begin
                        if (na_nxt == '0 || nb_nxt == '0) begin
                            zero_vec          <= 1'b1;
                            cosine_similarity <= '0;
                            dot_product       <= dot_nxt;
                            done              <= 1'b1;
                            busy              <= 1'b0;
                            state             <= S_DONE;
                        end else begin
                            zero_vec <= 1'b0;
                            rad      <= rad_init;
                            sq_root  <= '0;
                            sq_rem   <= '0;
                            cnt      <= '0;
                            state    <= S_SQRT;
                        end
                    end
                end
                S_SQRT: begin
                    rad     <= rad << 2;
                    sq_root <= sq_root_nxt;
                    sq_rem  <= sq_rem_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(SW - 1)) begin
                        dv_div <= sq_root_nxt;
                        dv_rem <= SW'(abs_dot) << (FRAC_W - 1);
                        quo    <= '0;
                        cnt    <= '0;
                        state  <= S_DIV;
                    end
                end
                S_DIV: begin
                    dv_rem <= dv_rem_nxt;
                    quo    <= quo_nxt[QW-2:0];
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(QW - 1)) begin
                        cosine_similarity <= cos_res;
                        dot_product       <= dot_acc;
                        done              <= 1'b1;
                        busy              <= 1'b0;
                        state             <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cosine_sim_engine.sv
// Bench for cosine_sim_engine: directed and random vectors against an arithmetic model,
// on the default build and an 8 x 4-bit build.
module tb_cosine_sim_engine;

    localparam int unsigned N_ELEM = 4;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned FRAC_W = 15;
    localparam int unsigned NW     = 2 * ELEM_W + $clog2(N_ELEM);
    localparam int unsigned LAT    = N_ELEM + (NW + FRAC_W) + (FRAC_W + 1);
    localparam int unsigned N8     = 8;
    localparam int unsigned E8     = 4;
    localparam int unsigned NW8    = 2 * E8 + $clog2(N8);
    localparam int unsigned LAT8   = N8 + (NW8 + FRAC_W) + (FRAC_W + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [31:0]       a_vec = '0;
    logic [31:0]       b_vec = '0;
    logic              busy, done, zero_vec;
    logic [NW:0]       dot_product;
    logic [FRAC_W:0]   cosine_similarity;

    logic              start8 = 1'b0;
    logic [31:0]       a8 = '0;
    logic [31:0]       b8 = '0;
    logic              busy8, done8, zero8;
    logic [NW8:0]      dot8;
    logic [FRAC_W:0]   cos8;

    int n_checks = 0;
    int n_pass   = 0;

    cosine_sim_engine #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .reset(reset), .start(start), .A_vec(a_vec), .B_vec(b_vec),
        .busy(busy), .done(done), .zero_vec(zero_vec),
        .dot_product(dot_product), .cosine_similarity(cosine_similarity)
    );

    cosine_sim_engine #(.N_ELEM(N8), .ELEM_W(E8), .FRAC_W(FRAC_W)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A_vec(a8), .B_vec(b8),
        .busy(busy8), .done(done8), .zero_vec(zero8),
        .dot_product(dot8), .cosine_similarity(cos8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic longint elem(input logic [31:0] v, input int i, input int ew);
        longint x;
        x = longint'((v >> (i * ew)) & ((32'd1 << ew) - 32'd1));
        if (x >= (longint'(1) << (ew - 1))) x = x - (longint'(1) << ew);
        return x;
    endfunction

    // Cosine from first principles: sums, binary-search isqrt, integer divide, rounding rules
    task automatic model(input logic [31:0] a, input logic [31:0] b, input int n, input int ew,
                         output longint dot, output logic [15:0] cos, output bit zero);
        longint na, nb, ai, bi, ad;
        logic [127:0] p, lo, hi, mid, q;
        dot = 0; na = 0; nb = 0;
        for (int i = 0; i < n; i++) begin
            ai = elem(a, i, ew);
            bi = elem(b, i, ew);
            dot += ai * bi;
            na  += ai * ai;
            nb  += bi * bi;
        end
        zero = (na == 0 || nb == 0);
        cos  = '0;
        if (!zero) begin
            p  = (128'(na) * 128'(nb)) << (2 * FRAC_W);
            lo = '0;
            hi = 128'(1) << 40;
            while (lo < hi) begin
                mid = (lo + hi + 128'(1)) >> 1;
                if (mid * mid <= p) lo = mid;
                else hi = mid - 128'(1);
            end
            ad = (dot < 0) ? -dot : dot;
            q  = (128'(ad) << (2 * FRAC_W)) / lo;
            if (dot >= 0) cos = (q >= (128'(1) << FRAC_W)) ? 16'h7FFF : 16'(q);
            else cos = 16'(-q);
        end
    endtask

    task automatic launch(input bit sel, input logic [31:0] a, input logic [31:0] b);
        if (sel) begin a8 = a; b8 = b; start8 = 1'b1; end
        else begin a_vec = a; b_vec = b; start = 1'b1; end
        @(posedge clk); #1;
        start = 1'b0; start8 = 1'b0;
        a_vec = ~a; b_vec = ~b; a8 = ~a; b8 = ~b;
    endtask

    task automatic wait_done(input bit sel, input int exp_lat, input string tag);
        int cyc = 0;
        while (!(sel ? done8 : done) && cyc < exp_lat + 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    endtask

    // One full operation; leaves the bench sampling in the DONE cycle unless linger is set
    task automatic run(input bit sel, input logic [31:0] a, input logic [31:0] b, input string tag,
                       input bit use_spec, input logic [15:0] spec_cos, input bit linger);
        longint edot;
        logic [15:0] ecos;
        bit ezero;
        logic [15:0] prev_cos;
        model(a, b, sel ? N8 : N_ELEM, sel ? E8 : ELEM_W, edot, ecos, ezero);
        prev_cos = sel ? cos8 : cosine_similarity;
        launch(sel, a, b);
        check({tag, "_busy"}, 64'(sel ? busy8 : busy), 64'(1));
        check({tag, "_hold"}, 64'(sel ? cos8 : cosine_similarity), 64'(prev_cos));
        wait_done(sel, ezero ? (sel ? N8 : N_ELEM) : (sel ? LAT8 : LAT), tag);
        check({tag, "_dot"}, sel ? 64'(longint'($signed(dot8))) : 64'(longint'($signed(dot_product))),
              64'(edot));
        check({tag, "_cos"}, 64'(sel ? cos8 : cosine_similarity), 64'(ecos));
        check({tag, "_zero"}, 64'(sel ? zero8 : zero_vec), 64'(ezero));
        check({tag, "_nbusy"}, 64'(sel ? busy8 : busy), 64'(0));
        if (use_spec) check({tag, "_spec"}, 64'(sel ? cos8 : cosine_similarity), 64'(spec_cos));
        if (linger) begin
            @(posedge clk); #1;
            check({tag, "_dfall"}, 64'(sel ? done8 : done), 64'(0));
            check({tag, "_keep"}, 64'(sel ? cos8 : cosine_similarity), 64'(ecos));
        end
    endtask

    initial begin
        int hits;
        logic [31:0] ra, rb;
        logic [15:0] kept;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_zero", 64'(zero_vec), 64'(0));
        check("rst_dot", 64'(dot_product), 64'(0));
        check("rst_cos", 64'(cosine_similarity), 64'(0));
        check("rst_cos8", 64'(cos8), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        run(0, 32'h01020304, 32'h01020304, "same", 1, 16'h7FFF, 1);
        run(0, 32'hFFFFFFFF, 32'h01010101, "opp", 1, 16'h8000, 1);
        run(0, 32'h01000000, 32'h00010000, "orth", 1, 16'h0000, 1);
        run(0, 32'h00000101, 32'h00000001, "ntriv", 1, 16'h5A82, 1);
        run(0, 32'h80808080, 32'h80808080, "maxneg", 1, 16'h7FFF, 1);
        run(0, 32'h80808080, 32'h7F7F7F7F, "antimax", 0, 16'h0, 1);

        // Zero-vector shortcut, then back-to-back start issued in the DONE cycle
        run(0, 32'h00000000, 32'h7F7F7F7F, "zvec", 1, 16'h0000, 0);
        launch(0, 32'h7F7F7F7F, 32'h7F7F7F7F);
        check("b2b_dfall", 64'(done), 64'(0));
        check("b2b_busy", 64'(busy), 64'(1));
        wait_done(0, LAT - 1 + 1, "b2b");
        check("b2b_cos", 64'(cosine_similarity), 64'(16'h7FFF));
        check("b2b_zero", 64'(zero_vec), 64'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            ra = $urandom();
            rb = $urandom();
            run(0, ra, rb, $sformatf("rnd%0d", i), 0, 16'h0, (i % 2) == 0);
        end
        @(posedge clk); #1;

        // start pulsed mid-SQRT must be ignored
        launch(0, 32'h01020304, 32'hFF030201);
        repeat (6) begin @(posedge clk); #1; end
        a_vec = 32'h7F7F7F7F; b_vec = 32'h7F7F7F7F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            longint ed; logic [15:0] ec; bit ez;
            model(32'h01020304, 32'hFF030201, N_ELEM, ELEM_W, ed, ec, ez);
            wait_done(0, LAT - 7, "sqst");
            check("sqst_cos", 64'(cosine_similarity), 64'(ec));
            check("sqst_dot", 64'(longint'($signed(dot_product))), 64'(ed));
        end
        hits = 0;
        repeat (70) begin @(posedge clk); #1; if (done) hits++; end
        check("sqst_single", 64'(hits), 64'(0));

        // Reset mid-DIV aborts without a done pulse
        kept = cosine_similarity;
        check("pre_rst_nz", 64'(kept != 16'h0), 64'(1));
        launch(0, 32'h05060708, 32'h01020304);
        repeat (42) begin @(posedge clk); #1; end
        check("mid_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_cos", 64'(cosine_similarity), 64'(0));
        check("arst_dot", 64'(dot_product), 64'(0));
        check("arst_zero", 64'(zero_vec), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        hits = 0;
        repeat (60) begin @(posedge clk); #1; if (done) hits++; end
        check("arst_nodone", 64'(hits), 64'(0));

        // Alternate build: 8 elements of 4 bits
        run(1, 32'h11111111, 32'h11111111, "e8same", 1, 16'h7FFF, 1);
        run(1, 32'h0000F000, 32'h12345678, "e8mix", 0, 16'h0, 1);
        for (int i = 0; i < 3; i++) begin
            ra = $urandom();
            rb = $urandom();
            run(1, ra, rb, $sformatf("e8rnd%0d", i), 0, 16'h0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
